led_mode_ctrl: RTL

- Button-driven sequencer for the board's 6-LED bank.
- Debounces the two active-low push buttons and runs a mode FSM (BLINK, COUNT, SHIFT).
- Owns the divided tick that paces every LED update.
- Sits between the raw board pins (btn1, btn2) and the led outputs, replacing ad-hoc per-cycle button polling in the top level.

---
 rtl/led_mode_ctrl_if.sv | 21 ++
 rtl/led_mode_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/led_mode_ctrl_if.sv
// rtl/led_mode_ctrl_if.sv - board-pin and LED bundle for the LED mode sequencer
interface led_mode_ctrl_if #(
  parameter int LED_W = 6
);
  logic             btn1;
  logic             btn2;
  logic [LED_W-1:0] led;
  logic [1:0]       mode;
  logic             running;
  logic             tick;

  modport master (
    output btn1, btn2,
    input  led, mode, running, tick
  );

  modport slave (
    input  btn1, btn2,
    output led, mode, running, tick
  );
endinterface

// File: rtl/led_mode_ctrl.sv
// rtl/led_mode_ctrl.sv - debounced two-button mode sequencer driving a paced LED bank
module led_mode_ctrl #(
  parameter int TICK_DIV     = 13500000,
  parameter int DEBOUNCE_CYC = 270000,
  parameter int LED_W        = 6
) (
  input  logic           clk,
  input  logic           rst,
  led_mode_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);

  function automatic logic [LED_W-1:0] blink_pat();
    logic [LED_W-1:0] p;
    for (int i = 0; i < LED_W; i++) p[i] = (i % 2 == 0);
    return p;
  endfunction

  localparam logic [LED_W-1:0] BLINK_INIT = blink_pat();
  localparam logic [LED_W-1:0] SHIFT_BOT  = LED_W'(1);
  localparam logic [LED_W-1:0] SHIFT_TOP  = LED_W'(1) << (LED_W - 1);

  typedef enum logic [1:0] {
    BLINK = 2'd0,
    COUNT = 2'd1,
    SHIFT = 2'd2
  } mode_e;

  // Bit 0 carries btn1, bit 1 carries btn2 throughout the input path.
  logic [1:0]       sync1_q, sync2_q, stable_q, stable_d, press;
  logic [DB_W-1:0]  db_cnt_q [2];
  logic [DB_W-1:0]  db_cnt_d [2];
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [LED_W-1:0] led_q, led_d;
  mode_e            mode_q, mode_d;
  logic             running_q, running_d;
  logic             tick_q, tick_d;
  logic             dir_left_q, dir_left_d;
  logic             wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      stable_q    <= 2'b11;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      tcnt_q      <= '0;
      led_q       <= BLINK_INIT;
      mode_q      <= BLINK;
      running_q   <= 1'b1;
      tick_q      <= 1'b0;
      dir_left_q  <= 1'b1;
    end else begin
      sync1_q     <= {bus.btn2, bus.btn1};
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      tcnt_q      <= tcnt_d;
      led_q       <= led_d;
      mode_q      <= mode_d;
      running_q   <= running_d;
      tick_q      <= tick_d;
      dir_left_q  <= dir_left_d;
    end
  end

  // Press fires on the same edge the stable level falls, so it is never a separate register stage.
  always_comb begin
    stable_d = stable_q;
    press    = 2'b00;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
          press[i]    = ~sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    mode_d     = mode_q;
    led_d      = led_q;
    tcnt_d     = tcnt_q;
    running_d  = running_q;
    dir_left_d = dir_left_q;
    tick_d     = 1'b0;
    wrap       = running_q && (tcnt_q == TICK_LAST);

    if (running_q) tcnt_d = wrap ? '0 : tcnt_q + CNT_W'(1);

    if (wrap) begin
      tick_d = 1'b1;
      case (mode_q)
        BLINK: led_d = ~led_q;
        COUNT: led_d = led_q + LED_W'(1);
        SHIFT: begin
          if (dir_left_q) begin
            led_d = led_q << 1;
            if (led_d == SHIFT_TOP) dir_left_d = 1'b0;
          end else begin
            led_d = led_q >> 1;
            if (led_d == SHIFT_BOT) dir_left_d = 1'b1;
          end
        end
        default: led_d = led_q;
      endcase
    end

    if (press[1]) running_d = ~running_q;

    // A mode change overrides any step landing on the same edge.
    if (press[0]) begin
      tcnt_d     = '0;
      dir_left_d = 1'b1;
      tick_d     = 1'b0;
      if (press[1]) running_d = 1'b1;
      case (mode_q)
        BLINK: begin
          mode_d = COUNT;
          led_d  = '0;
        end
        COUNT: begin
          mode_d = SHIFT;
          led_d  = SHIFT_BOT;
        end
        default: begin
          mode_d = BLINK;
          led_d  = BLINK_INIT;
        end
      endcase
    end
  end

  assign bus.led     = led_q;
  assign bus.mode    = mode_q;
  assign bus.running = running_q;
  assign bus.tick    = tick_q;
endmodule
